mem_arb: RTL and testbench

Two-master arbiter and sequencer for the single physical-memory SRAM port (DPI-backed pmem with 1-cycle registered read). Shares that port between the IFU (read-only) and the LSU (read/write). Round-robin grant, one outstanding transaction, response routing back to the owner, and a watchdog timeout. Sits between ifu/lsu and the SRAM wrapper.

---
 rtl/mem_arb_if.sv | 48 ++++
 rtl/mem_arb.sv | 103 ++++++++++
 tb/tb_mem_arb.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// Bundle of IFU/LSU request-response channels and the shared SRAM port seen by mem_arb.
// The slave view belongs to the arbiter; the master view belongs to the masters and the SRAM model.
interface mem_arb_if #(
  parameter int CPU_WIDTH = 32
);
  logic                   ifu_req_valid;
  logic                   ifu_req_ready;
  logic [CPU_WIDTH-1:0]   ifu_addr;
  logic                   ifu_rsp_valid;
  logic [CPU_WIDTH-1:0]   ifu_rdata;
  logic                   ifu_rsp_err;

  logic                   lsu_req_valid;
  logic                   lsu_req_ready;
  logic                   lsu_wen;
  logic [CPU_WIDTH-1:0]   lsu_addr;
  logic [CPU_WIDTH-1:0]   lsu_wdata;
  logic [CPU_WIDTH/8-1:0] lsu_wmask;
  logic                   lsu_rsp_valid;
  logic [CPU_WIDTH-1:0]   lsu_rdata;
  logic                   lsu_rsp_err;

  logic                   sram_ren;
  logic                   sram_wen;
  logic [CPU_WIDTH-1:0]   sram_addr;
  logic [CPU_WIDTH-1:0]   sram_wdata;
  logic [CPU_WIDTH/8-1:0] sram_wmask;
  logic [CPU_WIDTH-1:0]   sram_rdata;
  logic                   sram_resp_valid;

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
    input  sram_ren, sram_wen, sram_addr, sram_wdata, sram_wmask,
    output sram_rdata, sram_resp_valid
  );

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
    output sram_ren, sram_wen, sram_addr, sram_wdata, sram_wmask,
    input  sram_rdata, sram_resp_valid
  );
endinterface

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one SRAM port between IFU and LSU, one transaction in flight,
// with responses forwarded combinationally to the owner and a watchdog that completes with error.
module mem_arb #(
  parameter int CPU_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mem_arb_if.slave      bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IFU = 2'd1,
    WAIT_LSU = 2'd2
  } state_t;

  state_t           state_reg;
  logic             last_lsu_reg;
  logic             lsu_wr_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             in_idle;
  logic             grant_ifu;
  logic             grant_lsu;
  logic             wait_ifu;
  logic             wait_lsu;
  logic             at_last;
  logic             rsp_fire;
  logic             rsp_err;

  // Outputs are gated by reset so nothing leaks while i_rst_n is low.
  assign in_idle   = i_rst_n && (state_reg == IDLE);
  assign grant_ifu = in_idle && bus.ifu_req_valid && (!bus.lsu_req_valid || last_lsu_reg);
  assign grant_lsu = in_idle && bus.lsu_req_valid && (!bus.ifu_req_valid || !last_lsu_reg);
  assign wait_ifu  = i_rst_n && (state_reg == WAIT_IFU);
  assign wait_lsu  = i_rst_n && (state_reg == WAIT_LSU);
  assign at_last   = (cnt_reg == TO_LAST);
  assign rsp_fire  = bus.sram_resp_valid || at_last;
  assign rsp_err   = !bus.sram_resp_valid && at_last;

  assign bus.ifu_req_ready = grant_ifu;
  assign bus.lsu_req_ready = grant_lsu;

  assign bus.sram_ren  = grant_ifu || (grant_lsu && !bus.lsu_wen);
  assign bus.sram_wen  = grant_lsu && bus.lsu_wen;
  assign bus.sram_addr = grant_ifu ? bus.ifu_addr :
                         grant_lsu ? bus.lsu_addr : '0;

  logic [CPU_WIDTH-1:0]   wdata_lane;
  logic [CPU_WIDTH/8-1:0] wmask_lane;

  for (genvar gi = 0; gi < CPU_WIDTH / 8; gi++) begin : g_lane
    assign wdata_lane[gi*8 +: 8] = grant_lsu ? bus.lsu_wdata[gi*8 +: 8] : 8'h00;
    assign wmask_lane[gi]        = grant_lsu && bus.lsu_wmask[gi];
  end

  assign bus.sram_wdata = wdata_lane;
  assign bus.sram_wmask = wmask_lane;

  assign bus.ifu_rsp_valid = wait_ifu && rsp_fire;
  assign bus.ifu_rsp_err   = wait_ifu && rsp_err;
  assign bus.ifu_rdata     = (wait_ifu && bus.sram_resp_valid) ? bus.sram_rdata : '0;

  // Writes complete with zero data even though the SRAM bus may carry stale read data.
  assign bus.lsu_rsp_valid = wait_lsu && rsp_fire;
  assign bus.lsu_rsp_err   = wait_lsu && rsp_err;
  assign bus.lsu_rdata     = (wait_lsu && bus.sram_resp_valid && !lsu_wr_reg) ? bus.sram_rdata : '0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      last_lsu_reg <= 1'b1;
      lsu_wr_reg   <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_ifu) begin
            state_reg    <= WAIT_IFU;
            last_lsu_reg <= 1'b0;
            cnt_reg      <= '0;
          end else if (grant_lsu) begin
            state_reg    <= WAIT_LSU;
            last_lsu_reg <= 1'b1;
            lsu_wr_reg   <= bus.lsu_wen;
            cnt_reg      <= '0;
          end
        end
        WAIT_IFU, WAIT_LSU: begin
          if (rsp_fire) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: stimulus queues expected SRAM strobes and responses with their
// cycle stamps; a negedge monitor pops and compares whenever the DUT presents one.
module tb_mem_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arb_if #(.CPU_WIDTH(32)) bus ();

  mem_arb #(.CPU_WIDTH(32), .TIMEOUT(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int          cyc;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } sram_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } rsp_exp_t;

  sram_exp_t exp_sram[$];
  rsp_exp_t  exp_ifu[$];
  rsp_exp_t  exp_lsu[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("[TB] FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ifu_req_valid   = 1'b0;
    bus.ifu_addr        = '0;
    bus.lsu_req_valid   = 1'b0;
    bus.lsu_wen         = 1'b0;
    bus.lsu_addr        = '0;
    bus.lsu_wdata       = '0;
    bus.lsu_wmask       = '0;
    bus.sram_rdata      = '0;
    bus.sram_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ifu_ready"}, 32'(bus.ifu_req_ready), 32'd0);
    check({tag, " lsu_ready"}, 32'(bus.lsu_req_ready), 32'd0);
    check({tag, " ifu_rsp"},   32'({bus.ifu_rsp_valid, bus.ifu_rsp_err}), 32'd0);
    check({tag, " lsu_rsp"},   32'({bus.lsu_rsp_valid, bus.lsu_rsp_err}), 32'd0);
    check({tag, " ifu_rdata"}, bus.ifu_rdata, 32'd0);
    check({tag, " lsu_rdata"}, bus.lsu_rdata, 32'd0);
    check({tag, " strobes"},   32'({bus.sram_ren, bus.sram_wen}), 32'd0);
    check({tag, " sram_addr"}, bus.sram_addr, 32'd0);
    check({tag, " sram_wdata"}, bus.sram_wdata, 32'd0);
    check({tag, " sram_wmask"}, 32'(bus.sram_wmask), 32'd0);
  endtask

  // Monitor: compares every presented output against the head of its queue.
  sram_exp_t es;
  rsp_exp_t  er;
  always @(negedge clk) begin
    if (bus.sram_ren || bus.sram_wen) begin
      if (exp_sram.size() == 0) begin
        flag("sram unexpected strobe");
      end else begin
        es = exp_sram.pop_front();
        check("sram cycle", 32'(cyc), 32'(es.cyc));
        check("sram ren",   32'(bus.sram_ren), 32'(!es.wr));
        check("sram wen",   32'(bus.sram_wen), 32'(es.wr));
        check("sram addr",  bus.sram_addr, es.addr);
        check("sram wdata", bus.sram_wdata, es.wdata);
        check("sram wmask", 32'(bus.sram_wmask), 32'(es.mask));
      end
    end
    if (bus.ifu_rsp_valid) begin
      if (exp_ifu.size() == 0) begin
        flag("ifu unexpected rsp");
      end else begin
        er = exp_ifu.pop_front();
        check("ifu rsp cycle", 32'(cyc), 32'(er.cyc));
        check("ifu rdata",     bus.ifu_rdata, er.rdata);
        check("ifu err",       32'(bus.ifu_rsp_err), 32'(er.err));
      end
    end else if (bus.ifu_rsp_err) begin
      flag("ifu err without valid");
    end
    if (bus.lsu_rsp_valid) begin
      if (exp_lsu.size() == 0) begin
        flag("lsu unexpected rsp");
      end else begin
        er = exp_lsu.pop_front();
        check("lsu rsp cycle", 32'(cyc), 32'(er.cyc));
        check("lsu rdata",     bus.lsu_rdata, er.rdata);
        check("lsu err",       32'(bus.lsu_rsp_err), 32'(er.err));
      end
    end else if (bus.lsu_rsp_err) begin
      flag("lsu err without valid");
    end
  end

  initial begin
    // Reset with every input active: outputs must stay quiet.
    clear_inputs();
    bus.ifu_req_valid   = 1'b1;
    bus.lsu_req_valid   = 1'b1;
    bus.sram_resp_valid = 1'b1;
    bus.sram_rdata      = 32'hA5A5_A5A5;
    tick();
    check_all_zero("reset");
    do_reset();

    // IFU only read
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0000;
    exp_sram.push_back('{cyc, 1'b0, 32'h8000_0000, 32'h0, 4'h0});
    #1 check("t1 ifu_ready", 32'(bus.ifu_req_ready), 32'd1);
    check("t1 lsu_ready", 32'(bus.lsu_req_ready), 32'd0);
    tick();
    bus.ifu_req_valid   = 1'b0;
    bus.sram_resp_valid = 1'b1;
    bus.sram_rdata      = 32'h0000_0413;
    exp_ifu.push_back('{cyc, 32'h0000_0413, 1'b0});
    tick();
    clear_inputs();

    // Contention after reset: IFU, LSU, IFU, LSU on every other cycle
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.ifu_req_valid   = 1'b1;
      bus.ifu_addr        = 32'h8000_0100;
      bus.lsu_req_valid   = 1'b1;
      bus.lsu_wen         = 1'b0;
      bus.lsu_addr        = 32'h8000_2000;
      bus.sram_resp_valid = 1'b0;
      exp_sram.push_back('{cyc, 1'b0, (k % 2 == 0) ? 32'h8000_0100 : 32'h8000_2000, 32'h0, 4'h0});
      tick();
      bus.sram_resp_valid = 1'b1;
      bus.sram_rdata      = 32'h0000_1000 + 32'(k);
      if (k % 2 == 0) exp_ifu.push_back('{cyc, 32'h0000_1000 + 32'(k), 1'b0});
      else            exp_lsu.push_back('{cyc, 32'h0000_1000 + 32'(k), 1'b0});
      #1 check("rsp cycle ready", 32'({bus.ifu_req_ready, bus.lsu_req_ready}), 32'd0);
      tick();
    end
    clear_inputs();

    // LSU write: rdata on the SRAM bus must not reach the LSU
    bus.lsu_req_valid = 1'b1;
    bus.lsu_wen       = 1'b1;
    bus.lsu_addr      = 32'h8000_1000;
    bus.lsu_wdata     = 32'hDEAD_BEEF;
    bus.lsu_wmask     = 4'b0011;
    exp_sram.push_back('{cyc, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011});
    tick();
    clear_inputs();
    bus.sram_resp_valid = 1'b1;
    bus.sram_rdata      = 32'hCAFE_F00D;
    exp_lsu.push_back('{cyc, 32'h0, 1'b0});
    tick();
    clear_inputs();

    // Timeout: no response, error exactly 4 cycles after handshake, late response ignored
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0040;
    exp_sram.push_back('{cyc, 1'b0, 32'h8000_0040, 32'h0, 4'h0});
    exp_ifu.push_back('{cyc + 4, 32'h0, 1'b1});
    tick();
    bus.ifu_req_valid = 1'b0;
    bus.sram_rdata    = 32'hFFFF_FFFF;
    repeat (4) tick();
    bus.sram_resp_valid = 1'b1;
    bus.sram_rdata      = 32'h0000_0055;
    tick();
    clear_inputs();

    // Response arriving on the expiry cycle wins
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0080;
    exp_sram.push_back('{cyc, 1'b0, 32'h8000_0080, 32'h0, 4'h0});
    exp_ifu.push_back('{cyc + 4, 32'h1234_5678, 1'b0});
    tick();
    bus.ifu_req_valid = 1'b0;
    repeat (3) tick();
    bus.sram_resp_valid = 1'b1;
    bus.sram_rdata      = 32'h1234_5678;
    tick();
    clear_inputs();

    // Reset in WAIT_LSU: response discarded, next contention grants IFU
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_3000;
    exp_sram.push_back('{cyc, 1'b0, 32'h8000_3000, 32'h0, 4'h0});
    tick();
    rst_n               = 1'b0;
    bus.ifu_req_valid   = 1'b1;
    bus.lsu_req_valid   = 1'b1;
    bus.sram_resp_valid = 1'b1;
    bus.sram_rdata      = 32'h0BAD_0BAD;
    #1 check_all_zero("mid reset");
    tick();
    rst_n             = 1'b1;
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    tick();
    bus.sram_resp_valid = 1'b0;
    bus.ifu_req_valid   = 1'b1;
    bus.ifu_addr        = 32'h8000_0200;
    bus.lsu_req_valid   = 1'b1;
    bus.lsu_addr        = 32'h8000_4000;
    exp_sram.push_back('{cyc, 1'b0, 32'h8000_0200, 32'h0, 4'h0});
    #1 check("post reset ifu_ready", 32'(bus.ifu_req_ready), 32'd1);
    tick();
    clear_inputs();
    bus.sram_resp_valid = 1'b1;
    bus.sram_rdata      = 32'h7777_0001;
    exp_ifu.push_back('{cyc, 32'h7777_0001, 1'b0});
    tick();
    clear_inputs();

    repeat (3) tick();
    while (exp_sram.size() > 0) begin void'(exp_sram.pop_front()); flag("sram strobe missing"); end
    while (exp_ifu.size() > 0)  begin void'(exp_ifu.pop_front());  flag("ifu rsp missing"); end
    while (exp_lsu.size() > 0)  begin void'(exp_lsu.pop_front());  flag("lsu rsp missing"); end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
